// File: rtl/fsm_mestre_cq_pkg.sv
// Shared definitions for the CQ-stage master FSM: state encoding and
// default parameter values. The optional timeout feature is enabled by
// defining FSM_MESTRE_TIMEOUT_EN.
package fsm_mestre_cq_pkg;

   // 3-bit state encoding; the value 7 is unused and recovers to IDLE
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SOLICITA = 3'd1,
      LIBERA   = 3'd2,
      AVANCA   = 3'd3,
      DESCARTA = 3'd4,
      FIM      = 3'd5,
      ERRO     = 3'd6
   } estado_t;

   localparam int DESCARTE_CICLOS_DEF = 4;
   localparam int CONT_W_DEF          = 8;
   localparam int TIMEOUT_CICLOS_DEF  = 1000;

endpackage

// File: rtl/fsm_mestre_cq_contador_saturante.sv
// Saturating up-counter: counts i_inc pulses, sticks at all-ones,
// cleared synchronously by reset.
module contador_saturante #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_inc,
   output logic [W-1:0] o_valor
);

   logic [W-1:0] r_valor;

   // Increment on request unless already at the maximum value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valor <= '0;
      end else if (i_inc && (r_valor != {W{1'b1}})) begin
         r_valor <= r_valor + 1'b1;
      end
   end

   assign o_valor = r_valor;

endmodule

// File: rtl/fsm_mestre_cq.sv
// Master-side Moore FSM for the quality-control station: runs the
// request/answer/release handshake with the CQ slave, then pulses the
// forward command or holds the discard actuator. Counts approved and
// rejected bottles. Define FSM_MESTRE_TIMEOUT_EN to add a bounded wait
// in SOLICITA with an ERRO state cleared by limpa_erro.
module fsm_mestre_cq
   import fsm_mestre_cq_pkg::*;
#(
   parameter int DESCARTE_CICLOS = DESCARTE_CICLOS_DEF,
   parameter int CONT_W          = CONT_W_DEF
`ifdef FSM_MESTRE_TIMEOUT_EN
   , parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inicio_ciclo,
   input  logic              tarefa_concluida,
   input  logic              garrafa_aprovada,
   input  logic              limpa_erro,
   output logic              cmd_verificar,
   output logic              cmd_avancar,
   output logic              cmd_descarte,
   output logic              ciclo_concluido,
   output logic              ocupado,
   output logic [CONT_W-1:0] cont_aprovadas,
   output logic [CONT_W-1:0] cont_reprovadas,
   output logic              erro_timeout
);

   localparam int DESC_W = (DESCARTE_CICLOS > 1) ? $clog2(DESCARTE_CICLOS) : 1;

   estado_t           r_state;
   estado_t           w_state_next;
   logic              r_aprov;
   logic [DESC_W-1:0] r_desc;
   logic [1:0]        w_inc;
   logic [CONT_W-1:0] w_cont [2];

`ifdef FSM_MESTRE_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CICLOS + 1);
   logic [TO_W-1:0] r_to;

   // Timeout counter runs only in SOLICITA, so it is zero on every entry
   always_ff @(posedge clk) begin
      if (reset || (r_state != SOLICITA)) begin
         r_to <= '0;
      end else begin
         r_to <= r_to + 1'b1;
      end
   end
`else
   logic w_unused_limpa;
   assign w_unused_limpa = limpa_erro;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (inicio_ciclo) w_state_next = SOLICITA;
         SOLICITA: begin
            if (tarefa_concluida) begin
               w_state_next = LIBERA;
`ifdef FSM_MESTRE_TIMEOUT_EN
            end else if (r_to == TO_W'(TIMEOUT_CICLOS - 1)) begin
               w_state_next = ERRO;
`endif
            end
         end
         // Slave must drop its answer before the outcome is commanded
         LIBERA:   if (!tarefa_concluida) w_state_next = r_aprov ? AVANCA : DESCARTA;
         AVANCA:   w_state_next = FIM;
         DESCARTA: if (r_desc == '0) w_state_next = FIM;
         FIM:      w_state_next = IDLE;
`ifdef FSM_MESTRE_TIMEOUT_EN
         ERRO:     if (limpa_erro) w_state_next = IDLE;
`else
         ERRO:     w_state_next = IDLE;
`endif
         default:  w_state_next = IDLE;
      endcase
   end

   // Capture the slave's decision while it is being presented
   always_ff @(posedge clk) begin
      if (reset) begin
         r_aprov <= 1'b0;
      end else if ((r_state == SOLICITA) && tarefa_concluida) begin
         r_aprov <= garrafa_aprovada;
      end
   end

   // Discard length counter: loaded on entry, counts down to zero
   always_ff @(posedge clk) begin
      if (reset) begin
         r_desc <= '0;
      end else if ((r_state == LIBERA) && (w_state_next == DESCARTA)) begin
         r_desc <= DESC_W'(DESCARTE_CICLOS - 1);
      end else if ((r_state == DESCARTA) && (r_desc != '0)) begin
         r_desc <= r_desc - 1'b1;
      end
   end

   // Outputs decoded from the state register only
   always_comb begin
      cmd_verificar   = 1'b0;
      cmd_avancar     = 1'b0;
      cmd_descarte    = 1'b0;
      ciclo_concluido = 1'b0;
      erro_timeout    = 1'b0;
      ocupado         = (r_state != IDLE);
      case (r_state)
         SOLICITA: cmd_verificar   = 1'b1;
         AVANCA:   cmd_avancar     = 1'b1;
         DESCARTA: cmd_descarte    = 1'b1;
         FIM:      ciclo_concluido = 1'b1;
`ifdef FSM_MESTRE_TIMEOUT_EN
         ERRO:     erro_timeout    = 1'b1;
`endif
         default:  ;
      endcase
   end

   // Counters bump on the edge that leaves LIBERA: index 0 approved, 1 rejected
   assign w_inc[0] = (r_state == LIBERA) && !tarefa_concluida &&  r_aprov;
   assign w_inc[1] = (r_state == LIBERA) && !tarefa_concluida && !r_aprov;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cont
         contador_saturante #(.W(CONT_W)) u_cont (
            .clk     (clk),
            .reset   (reset),
            .i_inc   (w_inc[gi]),
            .o_valor (w_cont[gi])
         );
      end
   endgenerate

   assign cont_aprovadas  = w_cont[0];
   assign cont_reprovadas = w_cont[1];

endmodule

// File: tb/tb_fsm_mestre_cq.sv
// Directed testbench for fsm_mestre_cq (CONT_W=2, DESCARTE_CICLOS=4).
// The timeout scenario runs only when FSM_MESTRE_TIMEOUT_EN is defined.
module tb_fsm_mestre_cq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       inicio_ciclo = 1'b0;
   logic       tarefa_concluida = 1'b0;
   logic       garrafa_aprovada = 1'b0;
   logic       limpa_erro = 1'b0;
   logic       cmd_verificar, cmd_avancar, cmd_descarte, ciclo_concluido;
   logic       ocupado, erro_timeout;
   logic [1:0] cont_aprovadas, cont_reprovadas;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_av   = 0;
   int n_ds   = 0;
   int n_cc   = 0;

   fsm_mestre_cq #(
      .DESCARTE_CICLOS (4),
      .CONT_W          (2)
`ifdef FSM_MESTRE_TIMEOUT_EN
      , .TIMEOUT_CICLOS (20)
`endif
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .inicio_ciclo     (inicio_ciclo),
      .tarefa_concluida (tarefa_concluida),
      .garrafa_aprovada (garrafa_aprovada),
      .limpa_erro       (limpa_erro),
      .cmd_verificar    (cmd_verificar),
      .cmd_avancar      (cmd_avancar),
      .cmd_descarte     (cmd_descarte),
      .ciclo_concluido  (ciclo_concluido),
      .ocupado          (ocupado),
      .cont_aprovadas   (cont_aprovadas),
      .cont_reprovadas  (cont_reprovadas),
      .erro_timeout     (erro_timeout)
   );

   always #10 clk = ~clk;

   // Running totals of high cycles per pulse output, sampled mid-cycle
   always @(negedge clk) begin
      n_av <= n_av + int'(cmd_avancar);
      n_ds <= n_ds + int'(cmd_descarte);
      n_cc <= n_cc + int'(ciclo_concluido);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One bottle through the handshake. hold = extra cycles the slave keeps
   // tarefa_concluida high after cmd_verificar falls; extra = spurious
   // inicio_ciclo while busy; abort = reset on the 2nd discard cycle.
   task automatic bottle(input logic aprov, input int hold, input bit extra, input bit abort);
      int av0, ds0, cc0;
      av0 = n_av; ds0 = n_ds; cc0 = n_cc;
      inicio_ciclo = 1'b1;
      tick();
      inicio_ciclo = extra;
      chk("verif_on", {31'd0, cmd_verificar}, 32'd1);
      repeat (4) tick();
      chk("verif_wait", {31'd0, cmd_verificar}, 32'd1);
      tarefa_concluida = 1'b1;
      garrafa_aprovada = aprov;
      tick();
      chk("verif_off", {31'd0, cmd_verificar}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("libera_hold", {30'd0, cmd_avancar, cmd_descarte}, 32'd0);
         chk("libera_busy", {31'd0, ocupado}, 32'd1);
      end
      tarefa_concluida = 1'b0;
      garrafa_aprovada = 1'b0;
      inicio_ciclo = 1'b0;
      tick();
      if (aprov) begin
         chk("avanca_on", {31'd0, cmd_avancar}, 32'd1);
         tick();
         chk("avanca_off", {31'd0, cmd_avancar}, 32'd0);
         chk("fim_pulse", {31'd0, ciclo_concluido}, 32'd1);
      end else begin
         chk("desc_1", {31'd0, cmd_descarte}, 32'd1);
         tick();
         chk("desc_2", {31'd0, cmd_descarte}, 32'd1);
         if (abort) begin
            reset = 1'b1;
            tick();
            chk("rst_outs", {26'd0, cmd_verificar, cmd_avancar, cmd_descarte,
                             ciclo_concluido, ocupado, erro_timeout}, 32'd0);
            chk("rst_conts", {28'd0, cont_aprovadas, cont_reprovadas}, 32'd0);
            reset = 1'b0;
            return;
         end
         for (int i = 3; i <= 4; i++) begin
            tick();
            chk("desc_n", {31'd0, cmd_descarte}, 32'd1);
         end
         tick();
         chk("desc_off", {31'd0, cmd_descarte}, 32'd0);
         chk("fim_pulse", {31'd0, ciclo_concluido}, 32'd1);
      end
      tick();
      chk("fim_off", {31'd0, ciclo_concluido}, 32'd0);
      chk("idle_free", {31'd0, ocupado}, 32'd0);
      chk("n_avancar", av0 == n_av ? 32'd0 : 32'(n_av - av0), aprov ? 32'd1 : 32'd0);
      chk("n_descarte", 32'(n_ds - ds0), aprov ? 32'd0 : 32'd4);
      chk("n_concluido", 32'(n_cc - cc0), 32'd1);
   endtask

   initial begin
      repeat (2) tick();
      chk("reset_outs", {26'd0, cmd_verificar, cmd_avancar, cmd_descarte,
                         ciclo_concluido, ocupado, erro_timeout}, 32'd0);
      chk("reset_conts", {28'd0, cont_aprovadas, cont_reprovadas}, 32'd0);
      reset = 1'b0;
      tick();

      // Approved bottle
      bottle(1'b1, 1, 1'b0, 1'b0);
      chk("aprov_cnt1", {30'd0, cont_aprovadas}, 32'd1);
      chk("reprov_cnt0", {30'd0, cont_reprovadas}, 32'd0);

      // Rejected bottle
      bottle(1'b0, 1, 1'b0, 1'b0);
      chk("reprov_cnt1", {30'd0, cont_reprovadas}, 32'd1);
      chk("aprov_cnt1b", {30'd0, cont_aprovadas}, 32'd1);

      // Slave holds its answer 10 cycles; extra inicio_ciclo while busy
      bottle(1'b1, 10, 1'b1, 1'b0);
      chk("aprov_cnt2", {30'd0, cont_aprovadas}, 32'd2);
      repeat (2) tick();
      chk("no_requeue", {31'd0, ocupado}, 32'd0);

      // Reset during discard
      bottle(1'b0, 1, 1'b0, 1'b1);
      tick();
      chk("post_rst_idle", {31'd0, ocupado}, 32'd0);

      // Saturation at 3 with a 2-bit counter
      for (int i = 1; i <= 5; i++) begin
         bottle(1'b1, 1, 1'b0, 1'b0);
         chk("sat_cnt", {30'd0, cont_aprovadas}, (i < 3) ? 32'(i) : 32'd3);
      end
      chk("sat_reprov", {30'd0, cont_reprovadas}, 32'd0);

`ifdef FSM_MESTRE_TIMEOUT_EN
      // Slave never answers
      inicio_ciclo = 1'b1;
      tick();
      inicio_ciclo = 1'b0;
      repeat (19) tick();
      chk("to_verif_on", {31'd0, cmd_verificar}, 32'd1);
      tick();
      chk("to_verif_off", {31'd0, cmd_verificar}, 32'd0);
      chk("to_erro", {31'd0, erro_timeout}, 32'd1);
      chk("to_conts", {28'd0, cont_aprovadas, cont_reprovadas}, 32'hC);
      limpa_erro = 1'b1;
      tick();
      limpa_erro = 1'b0;
      chk("to_clear", {30'd0, erro_timeout, ocupado}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
